// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle accumulator core: opcodes, system sub-codes,
// FSM states and register index names.
package core_pkg;

  localparam int unsigned NREGS = 4;

  localparam logic [3:0] OP_SYS      = 4'h0;
  localparam logic [3:0] OP_ADD      = 4'h1;
  localparam logic [3:0] OP_ADDI     = 4'h2;
  localparam logic [3:0] OP_SUB      = 4'h3;
  localparam logic [3:0] OP_MUL      = 4'h4;
  localparam logic [3:0] OP_NEG      = 4'h6;
  localparam logic [3:0] OP_BGEZ     = 4'h8;
  localparam logic [3:0] OP_BGEZ_ALT = 4'h9;
  localparam logic [3:0] OP_MOVE     = 4'hA;
  localparam logic [3:0] OP_ST       = 4'hB;
  localparam logic [3:0] OP_LD       = 4'hC;
  localparam logic [3:0] OP_LI       = 4'hD;
  localparam logic [3:0] OP_J        = 4'hE;

  // Full-byte encodings inside the OP_SYS group
  localparam logic [7:0] INSN_OUT  = 8'h02;
  localparam logic [7:0] INSN_HALT = 8'h0F;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALTED
  } state_t;

endpackage

// File: rtl/core_alu.sv
// Combinational arithmetic for the core: add, subtract, full-width multiply,
// negate and the signed >= 0 test used by BGEZ.
module core_alu #(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   add_c,
  output logic [DW-1:0]   sub_c,
  output logic [DW-1:0]   neg_c,
  output logic [2*DW-1:0] mul_c,
  output logic            ge_zero_c
);

  localparam int unsigned PW = 2 * DW;

  assign add_c     = a + b;
  assign sub_c     = a - b;
  assign neg_c     = DW'(0) - a;
  assign mul_c     = PW'(a) * PW'(b);
  assign ge_zero_c = ~a[DW-1];

endmodule

// File: rtl/param_multicycle_core.sv
// Multi-cycle accumulator core: fetch, execute and load/store share one memory
// port with a req/ready handshake; all outputs are registered.
module param_multicycle_core
  import core_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 7,
  parameter int unsigned CW       = 16,
  parameter int unsigned RESET_PC = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          halted,
  output logic [CW-1:0] cycle_count
);

  state_t        state;
  logic [AW-1:0] pc;
  logic [7:0]    ir;
  logic [DW-1:0] regs [NREGS];

  logic [3:0]    op;
  logic [1:0]    rd_i;
  logic [1:0]    rs_i;
  logic [DW-1:0] rd_v;
  logic [DW-1:0] rs_v;
  logic [DW-1:0] imm;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] next_pc;

  logic [DW-1:0]   add_c;
  logic [DW-1:0]   sub_c;
  logic [DW-1:0]   neg_c;
  logic [2*DW-1:0] mul_c;
  logic            ge_zero_c;

  assign op     = ir[7:4];
  assign rd_i   = ir[3:2];
  assign rs_i   = ir[1:0];
  assign rd_v   = regs[rd_i];
  assign rs_v   = regs[rs_i];
  assign imm    = DW'(ir[1:0]);
  assign pc_inc = pc + AW'(1);

  core_alu #(.DW(DW)) u_alu (
    .a         (rd_v),
    .b         (rs_v),
    .add_c     (add_c),
    .sub_c     (sub_c),
    .neg_c     (neg_c),
    .mul_c     (mul_c),
    .ge_zero_c (ge_zero_c)
  );

  // Program counter after the instruction currently held in ir
  always_comb begin
    next_pc = pc_inc;
    case (op)
      OP_BGEZ, OP_BGEZ_ALT: if (ge_zero_c) next_pc = AW'(rs_v);
      OP_J:                 next_pc = AW'(rd_v);
      OP_SYS:               if (ir == INSN_HALT) next_pc = pc;
      default:              ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= AW'(RESET_PC);
      ir          <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else begin
      out_valid <= 1'b0;
      if ((state == S_FETCH || state == S_EXEC || state == S_MEM) && cycle_count != '1)
        cycle_count <= cycle_count + CW'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            pc       <= AW'(RESET_PC);
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= AW'(RESET_PC);
          end
        end

        S_FETCH: begin
          if (mem_ready) begin
            ir      <= mem_rdata[7:0];
            state   <= S_EXEC;
            mem_req <= 1'b0;
          end
        end

        S_EXEC: begin
          pc <= next_pc;
          case (op)
            OP_ADD:  regs[R0] <= add_c;
            OP_ADDI: regs[rd_i] <= rd_v + imm;
            OP_SUB:  regs[R0] <= sub_c;
            OP_MUL: begin
              regs[R1] <= mul_c[2*DW-1:DW];
              regs[R0] <= mul_c[DW-1:0];
            end
            OP_NEG:  regs[R0] <= neg_c;
            OP_MOVE: regs[rd_i] <= rs_v;
            OP_LI:   regs[rd_i] <= imm;
            OP_J:    regs[R3] <= DW'(pc_inc);
            OP_SYS: begin
              if (ir == INSN_OUT) begin
                out_data  <= regs[R0];
                out_valid <= 1'b1;
              end
            end
            default: ;
          endcase

          // Pick the next bus transaction (or none when halting)
          if (op == OP_ST || op == OP_LD) begin
            state     <= S_MEM;
            mem_req   <= 1'b1;
            mem_we    <= (op == OP_ST);
            mem_addr  <= AW'(rs_v);
            mem_wdata <= rd_v;
          end else if (ir == INSN_HALT) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else begin
            state    <= S_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= next_pc;
          end
        end

        S_MEM: begin
          if (mem_ready) begin
            if (op == OP_LD) regs[rd_i] <= mem_rdata;
            state    <= S_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end

        S_HALTED: ;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_multicycle_core.sv
// Directed bench for param_multicycle_core: memory model with wait states,
// scoreboards for OUT values and store transactions, plus a narrow-counter instance.
module tb_param_multicycle_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mem_req;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       halted;
  logic [15:0] cycle_count;

  logic       start_s;
  logic       s_req;
  logic       s_we;
  logic [6:0] s_addr;
  logic [7:0] s_wdata;
  logic       s_ov;
  logic [7:0] s_od;
  logic       s_halted;
  logic [3:0] s_cc;

  logic [7:0]   mem  [128];
  logic [7:0]   wmem [128];
  logic [127:0] wvalid;
  int           wait_cnt;
  int           wait_n;
  logic         hold_ready;

  logic [7:0]  out_q [$];
  logic [15:0] wr_q  [$];
  logic [7:0]  code_q [$];
  int          n_out;
  int          total;
  int          bad;
  int          n0;

  always #5 clk = ~clk;

  param_multicycle_core #(.DW(8), .AW(7), .CW(16), .RESET_PC(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  param_multicycle_core #(.DW(8), .AW(7), .CW(4), .RESET_PC(32)) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_s),
    .mem_req     (s_req),
    .mem_we      (s_we),
    .mem_addr    (s_addr),
    .mem_wdata   (s_wdata),
    .mem_rdata   (8'h00),
    .mem_ready   (1'b1),
    .out_valid   (s_ov),
    .out_data    (s_od),
    .halted      (s_halted),
    .cycle_count (s_cc)
  );

  assign mem_ready = mem_req && !hold_ready && (wait_cnt >= wait_n);
  assign mem_rdata = wvalid[mem_addr] ? wmem[mem_addr] : mem[mem_addr];

  always @(posedge clk) begin
    if (!rst_n) begin
      wvalid   <= '0;
      wait_cnt <= 0;
    end else begin
      if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
      else                       wait_cnt <= 0;
      if (mem_req && mem_ready && mem_we) begin
        wmem[mem_addr]   <= mem_wdata;
        wvalid[mem_addr] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // OUT scoreboard
  always @(negedge clk) begin
    if (out_valid) begin
      n_out++;
      check("out_expected", 32'(out_q.size() != 0), 32'd1);
      if (out_q.size() != 0) check("out_data", 32'(out_data), 32'(out_q.pop_front()));
    end
  end

  // Store scoreboard: {addr, data} of every completed write
  always @(negedge clk) begin
    if (mem_req && mem_ready && mem_we) begin
      check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) check("wr_addr_data", 32'({1'b0, mem_addr, mem_wdata}), 32'(wr_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
  endtask

  task automatic load_code(input int base);
    foreach (code_q[i]) mem[(base + i) % 128] = code_q[i];
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; start_s = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic start_prog();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  task automatic end_prog(input string tag, input int cc_exp);
    step(); step();
    check({tag, "_cc"}, 32'(cycle_count), 32'(cc_exp));
    check({tag, "_outs_left"}, 32'(out_q.size()), 32'd0);
    check({tag, "_wr_left"}, 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; n_out = 0;
    wait_n = 0; hold_ready = 1'b0;
    clear_mem();
    do_reset();

    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cc", 32'(cycle_count), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // Zero-wait multiply program
    code_q = '{8'hD7, 8'hDA, 8'h46, 8'h02, 8'h0F};
    load_code(32);
    out_q.push_back(8'd6);
    n0 = n_out;
    start_prog();
    check("t2_first_addr", 32'(mem_addr), 32'd32);
    run_to_halt("t2_halt", 200);
    end_prog("t2", 10);
    check("t2_pulses", 32'(n_out - n0), 32'd1);
    check("t2_out_hold", 32'(out_data), 32'd6);

    // Reset in the middle of a stalled fetch
    clear_mem();
    code_q = '{8'hD7, 8'hDA, 8'hDD, 8'hD2};
    load_code(32);
    do_reset();
    start_prog();
    for (int i = 0; i < 8; i++) step();
    hold_ready = 1'b1;
    step(); step();
    check("t1_req_stall", 32'(mem_req), 32'd1);
    check("t1_addr_stall", 32'(mem_addr), 32'd36);
    rst_n = 1'b0;
    step();
    check("t1_req_after_rst", 32'(mem_req), 32'd0);
    check("t1_cc_after_rst", 32'(cycle_count), 32'd0);
    check("t1_halted_after_rst", 32'(halted), 32'd0);
    rst_n = 1'b1;
    hold_ready = 1'b0;
    clear_mem();
    code_q = '{8'h02, 8'hA1, 8'h02, 8'hA2, 8'h02, 8'hA3, 8'h02, 8'h0F};
    load_code(32);
    repeat (4) out_q.push_back(8'h00);
    start_prog();
    check("t1_pc_reset", 32'(mem_addr), 32'd32);
    run_to_halt("t1_halt", 200);
    end_prog("t1", 16);

    // Three wait states per transfer
    clear_mem();
    code_q = '{8'h21, 8'h02, 8'h0F};
    load_code(32);
    do_reset();
    wait_n = 3;
    out_q.push_back(8'd1);
    start_prog();
    for (int i = 0; i < 4; i++) begin
      check("t3_req_stable", 32'(mem_req), 32'd1);
      check("t3_addr_stable", 32'(mem_addr), 32'd32);
      step();
    end
    check("t3_exec_no_req", 32'(mem_req), 32'd0);
    run_to_halt("t3_halt", 300);
    end_prog("t3", 15);
    wait_n = 0;

    // Store then load through the same address
    clear_mem();
    code_q = '{8'hD6, 8'h27, 8'hB5, 8'hC9, 8'hA2, 8'h02, 8'h0F};
    load_code(32);
    do_reset();
    wr_q.push_back({8'd5, 8'd5});
    out_q.push_back(8'd5);
    start_prog();
    run_to_halt("t4_halt", 200);
    end_prog("t4", 16);

    // BGEZ not-taken on 0x80, taken on 0x7F
    clear_mem();
    mem[1] = 8'h7F; mem[2] = 8'h80; mem[3] = 8'h02; mem[4] = 8'h0F;
    code_q = '{8'hD7, 8'hDA, 8'hC2, 8'h81, 8'h02, 8'hD9, 8'hC2, 8'h91, 8'hD0, 8'h02, 8'h0F};
    load_code(32);
    do_reset();
    out_q.push_back(8'h80);
    out_q.push_back(8'h7F);
    start_prog();
    run_to_halt("t5_halt", 300);
    end_prog("t5", 22);

    // J link value, pc wrap 127 -> 0, and J through r3 using its old value
    clear_mem();
    mem[0] = 8'h02; mem[1] = 8'h7F; mem[2] = 8'hEC; mem[127] = 8'hA3;
    code_q = '{8'hD9, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hE4, 8'hA3, 8'h02, 8'h0F};
    load_code(32);
    do_reset();
    out_q.push_back(8'd41);
    out_q.push_back(8'd3);
    start_prog();
    run_to_halt("t6j_halt", 300);
    end_prog("t6j", 33);

    // NEG and MUL high half
    clear_mem();
    code_q = '{8'hD1, 8'h60, 8'h02, 8'h40, 8'h02, 8'hA1, 8'h02, 8'h0F};
    load_code(32);
    do_reset();
    out_q.push_back(8'hFF);
    out_q.push_back(8'h01);
    out_q.push_back(8'hFE);
    start_prog();
    run_to_halt("t6n_halt", 200);
    end_prog("t6n", 16);

    // Narrow cycle counter saturates
    do_reset();
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("sat_cc_5", 32'(s_cc), 32'd5);
    check("sat_addr_5", 32'(s_addr), 32'd34);
    for (int i = 0; i < 40; i++) step();
    check("sat_cc_sticks", 32'(s_cc), 32'd15);
    check("sat_addr_45", 32'(s_addr), 32'd54);
    check("sat_req", 32'(s_req), 32'd0);
    check("sat_we", 32'(s_we), 32'd0);
    check("sat_wdata", 32'(s_wdata), 32'd0);
    check("sat_out", 32'({s_ov, s_od}), 32'd0);
    check("sat_halted", 32'(s_halted), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
